// File: rtl/binary_morph.sv
// binary_morph: 3x3 binary morphology (pass/erode/dilate/boundary) on a streamed image.
// Ports:
//   clk, rst_n          clock, asynchronous active-low reset
//   EN                  1 = processed path (2-cycle latency), 0 = combinational bypass
//   mode[1:0]           00 pass, 01 erode, 10 dilate, 11 boundary; latched at frame start
//   pre_vs/pre_de/pre_bit   input frame sync, data enable, binary pixel
//   post_vs/post_de/post_bit output frame sync, data enable, result pixel
module binary_morph #(
    parameter int IMG_WIDTH = 640,
    parameter int ROW_MAX   = 2047
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       EN,
    input  logic [1:0] mode,
    input  logic       pre_vs,
    input  logic       pre_de,
    input  logic       pre_bit,
    output logic       post_vs,
    output logic       post_de,
    output logic       post_bit
);
    localparam int CW = $clog2(IMG_WIDTH + 1);
    localparam int AW = $clog2(IMG_WIDTH);
    localparam int RW = $clog2(ROW_MAX + 1);
    localparam logic [CW-1:0] COL_SAT = CW'(IMG_WIDTH);
    localparam logic [RW-1:0] ROW_SAT = RW'(ROW_MAX);

    logic [CW-1:0] col_q, col_d;
    logic [RW-1:0] row_q, row_d;
    logic [8:0]    win_q, win_d;
    logic [1:0]    mode_q, mode_d;
    logic          valid_q, valid_d;
    logic          vs1_q, de1_q, vs2_q, de2_q;
    logic          res_q, res_d;
    logic          lb1 [IMG_WIDTH];
    logic          lb2 [IMG_WIDTH];
    logic          in_range, vs_rise, de_fall, lb1_rd, lb2_rd, erode, centre;
    logic [AW-1:0] idx;

    // vs1_q/de1_q double as the edge-detect copies of pre_vs/pre_de.
    always_comb begin
        in_range = col_q < COL_SAT;
        idx      = col_q[AW-1:0];
        lb1_rd   = in_range ? lb1[idx] : 1'b0;
        lb2_rd   = in_range ? lb2[idx] : 1'b0;
        vs_rise  = pre_vs & ~vs1_q;
        de_fall  = de1_q & ~pre_de;
        col_d    = !pre_de ? '0 : (col_q == COL_SAT) ? col_q : col_q + 1'b1;
        row_d    = vs_rise ? '0 : (de_fall && row_q != ROW_SAT) ? row_q + 1'b1 : row_q;
        mode_d   = vs_rise ? mode : mode_q;
        // Window columns: [2:0] = column c, [5:3] = c-1, [8:6] = c-2; bit order {row r, r-1, r-2}.
        win_d    = pre_de ? {win_q[5:0], pre_bit, lb1_rd, lb2_rd} : win_q;
        valid_d  = row_q >= RW'(2) && col_q >= CW'(2) && in_range;
        erode    = &win_q;
        centre   = win_q[4];
        res_d    = !(valid_q && de1_q) ? 1'b0 :
                   mode_q == 2'b00 ? centre :
                   mode_q == 2'b01 ? erode :
                   mode_q == 2'b10 ? |win_q : centre & ~erode;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            col_q   <= '0;
            row_q   <= '0;
            win_q   <= '0;
            mode_q  <= 2'b00;
            valid_q <= 1'b0;
            vs1_q   <= 1'b0;
            de1_q   <= 1'b0;
            vs2_q   <= 1'b0;
            de2_q   <= 1'b0;
            res_q   <= 1'b0;
        end else begin
            col_q   <= col_d;
            row_q   <= row_d;
            win_q   <= win_d;
            mode_q  <= mode_d;
            valid_q <= valid_d;
            vs1_q   <= pre_vs;
            de1_q   <= pre_de;
            vs2_q   <= vs1_q;
            de2_q   <= de1_q;
            res_q   <= res_d;
        end
    end

    // Line buffers hold no reset; stale rows are masked by the valid flag.
    always_ff @(posedge clk) begin
        if (pre_de && in_range) begin
            lb1[idx] <= pre_bit;
            lb2[idx] <= lb1[idx];
        end
    end

    assign post_vs  = EN ? vs2_q : pre_vs;
    assign post_de  = EN ? de2_q : pre_de;
    assign post_bit = EN & res_q;
endmodule

// File: tb/tb_binary_morph.sv
// tb_binary_morph: self-checking bench for binary_morph (table, directed frames, random vs model).
module tb_binary_morph;
    localparam int W = 8;

    logic clk = 0, rst_n = 1, EN = 1;
    logic [1:0] mode = 2'b00;
    logic pre_vs = 0, pre_de = 0, pre_bit = 0;
    logic post_vs, post_de, post_bit;

    binary_morph #(.IMG_WIDTH(W), .ROW_MAX(2047)) dut (
        .clk(clk), .rst_n(rst_n), .EN(EN), .mode(mode),
        .pre_vs(pre_vs), .pre_de(pre_de), .pre_bit(pre_bit),
        .post_vs(post_vs), .post_de(post_de), .post_bit(post_bit)
    );

    always #5 clk = ~clk;

    int checks = 0, failures = 0;
    int cyc = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s cyc=%0d actual=%0d required=%0d", name, cyc, act, exp);
        end
    endtask

    // Reference model: stores the frame's pixels and evaluates the 3x3 rule directly.
    logic img [64][16];
    logic pix [16][16];
    int mline, mcol;
    logic pv, pd;
    logic [1:0] mmode;
    logic [2:0] p1, p2;
    logic s_vs, s_de, s_bit;
    logic cap [$];

    function automatic logic op(int r, int c);
        int ones = 0;
        for (int i = r - 2; i <= r; i++)
            for (int j = c - 2; j <= c; j++)
                ones += int'(img[i][j]);
        case (mmode)
            2'b00:   return img[r-1][c-1];
            2'b01:   return ones == 9;
            2'b10:   return ones > 0;
            default: return img[r-1][c-1] && ones != 9;
        endcase
    endfunction

    task automatic model_reset();
        mline = 0; mcol = 0; pv = 0; pd = 0; mmode = 2'b00; p1 = '0; p2 = '0;
    endtask

    task automatic model_clk();
        logic b;
        b = 1'b0;
        if (pre_de && mcol < W && mline < 64) img[mline][mcol] = pre_bit;
        if (pre_de && mline >= 2 && mline < 64 && mcol >= 2 && mcol < W) b = op(mline, mcol);
        p2 = p1;
        p1 = {pre_vs, pre_de, b};
        mcol = pre_de ? mcol + 1 : 0;
        if (pre_vs && !pv) begin
            mline = 0;
            mmode = mode;
        end else if (pd && !pre_de) mline++;
        pv = pre_vs;
        pd = pre_de;
    endtask

    task automatic tick(input logic v, input logic d, input logic b);
        logic [2:0] e;
        @(negedge clk);
        pre_vs = v; pre_de = d; pre_bit = b;
        #1;
        e = EN ? p2 : {v, d, 1'b0};
        s_vs = post_vs; s_de = post_de; s_bit = post_bit;
        chk("cyc_vs", post_vs, e[2]);
        chk("cyc_de", post_de, e[1]);
        chk("cyc_bit", post_bit, e[0]);
        if (EN && post_de) cap.push_back(post_bit);
        @(posedge clk);
        model_clk();
        cyc++;
    endtask

    task automatic send_frame(input int h, input int l, input logic [1:0] m, input int mid_row, input logic [1:0] mid_mode);
        mode = m;
        tick(1, 0, 0); tick(1, 0, 0); tick(0, 0, 0); tick(0, 0, 0);
        for (int r = 0; r < h; r++) begin
            if (r == mid_row) mode = mid_mode;
            for (int c = 0; c < l; c++) tick(0, 1, pix[r][c]);
            tick(0, 0, 0); tick(0, 0, 0); tick(0, 0, 0);
        end
    endtask

    task automatic fill_pix(input int kind);
        for (int r = 0; r < 16; r++)
            for (int c = 0; c < 16; c++)
                pix[r][c] = (kind != 1);
        if (kind == 0) pix[3][3] = 1'b0;
        if (kind == 1) pix[2][2] = 1'b1;
    endtask

    function automatic logic exp_px(int kind, int r, int c);
        case (kind)
            0:       return r >= 2 && c >= 2 && !(r >= 3 && r <= 5 && c >= 3 && c <= 5);
            1:       return r >= 2 && r <= 4 && c >= 2 && c <= 4;
            2:       return r >= 2 && c >= 2;
            default: return r >= 2 && c >= 2 && c < W;
        endcase
    endfunction

    task automatic check_frame(input string name, input int kind, input int h, input int l);
        chk({name, "_count"}, cap.size(), h * l);
        for (int k = 0; k < cap.size() && k < h * l; k++)
            chk(name, cap[k], exp_px(kind, k / l, k % l));
    endtask

    typedef struct {
        logic vs, de, b;
        logic evs, ede, eb;
    } vec_t;
    vec_t tbl [8];

    initial begin
        #1000000;
        $display("FAIL watchdog expired");
        $fatal(1);
    end

    initial begin
        tbl[0] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0};
        tbl[1] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
        tbl[2] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
        tbl[3] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
        tbl[4] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0};
        tbl[5] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
        tbl[6] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0};
        tbl[7] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};

        // Power-on reset state with EN=1
        #1 rst_n = 0;
        #1;
        chk("rst_vs", post_vs, 0);
        chk("rst_de", post_de, 0);
        chk("rst_bit", post_bit, 0);
        @(posedge clk); @(posedge clk);
        @(negedge clk) rst_n = 1;
        model_reset();

        // Erode with one black pixel
        fill_pix(0); cap.delete();
        send_frame(6, 8, 2'b01, -1, 2'b00);
        check_frame("erode", 0, 6, 8);

        // Dilate a single white pixel
        fill_pix(1); cap.delete();
        send_frame(6, 8, 2'b10, -1, 2'b00);
        check_frame("dilate", 1, 6, 8);

        // Mode change mid-frame only takes effect at the next frame
        fill_pix(0); cap.delete();
        send_frame(6, 8, 2'b01, 3, 2'b10);
        check_frame("mode_hold", 0, 6, 8);
        cap.delete();
        send_frame(6, 8, 2'b10, -1, 2'b00);
        check_frame("mode_next", 2, 6, 8);

        // Overlong lines: extra pixels masked and do not disturb the next row
        fill_pix(2); cap.delete();
        send_frame(4, 10, 2'b01, -1, 2'b00);
        check_frame("overlong", 3, 4, 10);

        // Bypass table
        EN = 0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            pre_vs = tbl[i].vs; pre_de = tbl[i].de; pre_bit = tbl[i].b;
            #1;
            chk("byp_vs", post_vs, tbl[i].evs);
            chk("byp_de", post_de, tbl[i].ede);
            chk("byp_bit", post_bit, tbl[i].eb);
            @(posedge clk);
            model_clk();
            cyc++;
        end

        // Back to processed path: a single de pulse emerges two cycles later
        EN = 1;
        tick(0, 0, 0); tick(0, 0, 0);
        tick(0, 1, 0); chk("en_lat0", s_de, 0);
        tick(0, 0, 0); chk("en_lat1", s_de, 0);
        tick(0, 0, 0); chk("en_lat2", s_de, 1);

        // Reset mid-frame
        fill_pix(2);
        mode = 2'b01;
        tick(1, 0, 0); tick(0, 0, 0);
        for (int r = 0; r < 3; r++) begin
            for (int c = 0; c < 8; c++) tick(0, 1, pix[r][c]);
            tick(0, 0, 0);
        end
        tick(0, 1, 1); tick(0, 1, 1);
        #2;
        rst_n = 0;
        pre_vs = 1'($urandom); pre_de = 1'($urandom); pre_bit = 1'($urandom);
        #1;
        chk("midrst_vs", post_vs, 0);
        chk("midrst_de", post_de, 0);
        chk("midrst_bit", post_bit, 0);
        @(posedge clk); @(posedge clk);
        @(negedge clk);
        pre_vs = 0; pre_de = 0; pre_bit = 0;
        rst_n = 1;
        model_reset();
        tick(0, 1, 1); chk("rel_lat0", s_de, 0);
        tick(0, 0, 0); chk("rel_lat1", s_de, 0);
        tick(0, 0, 0); chk("rel_lat2", s_de, 1);
        fill_pix(0); cap.delete();
        send_frame(6, 8, 2'b01, -1, 2'b00);
        check_frame("after_rst", 0, 6, 8);

        // Random frames against the model
        for (int f = 0; f < 8; f++) begin
            int h, l, mr;
            h  = 3 + int'($urandom_range(0, 4));
            l  = 5 + int'($urandom_range(0, 5));
            mr = int'($urandom_range(0, 6));
            EN = ($urandom_range(0, 3) != 0);
            for (int r = 0; r < 16; r++)
                for (int c = 0; c < 16; c++)
                    pix[r][c] = ($urandom_range(0, 3) != 0);
            send_frame(h, l, 2'($urandom), mr, 2'($urandom));
        end
        EN = 1;
        tick(0, 0, 0); tick(0, 0, 0); tick(0, 0, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/binary_morph.md
BINARY_MORPH -- requirements
Module: binary_morph

Interface
REQ-001 Parameter IMG_WIDTH, default 640: maximum active pixels per line and line-buffer depth, legal range 4..4096.
REQ-002 Parameter ROW_MAX, default 2047: row-counter saturation value.
REQ-003 Port clk, input, 1: single clock; all state changes on the rising edge.
REQ-004 Port rst_n, input, 1: asynchronous, active-low reset.
REQ-005 Port EN, input, 1: 1 selects the processed path; 0 selects bypass.
REQ-006 Port mode, input, 2: operation select; 00 pass, 01 erode, 10 dilate, 11 boundary.
REQ-007 Port pre_vs, input, 1: frame sync; a rising edge marks frame start.
REQ-008 Port pre_de, input, 1: data enable; high for active pixels.
REQ-009 Port pre_bit, input, 1: binary pixel, 1 = white, 0 = black.
REQ-010 Port post_vs, output, 1: delayed frame sync.
REQ-011 Port post_de, output, 1: delayed data enable.
REQ-012 Port post_bit, output, 1: morphological result.

Function
REQ-013 Column counter col: cleared while pre_de=0; increments on each pre_de=1 cycle; saturates at IMG_WIDTH.
REQ-014 Row counter row: cleared on a pre_vs rising edge (detected against a 1-cycle registered copy of pre_vs); increments on each pre_de falling edge; saturates at ROW_MAX.
REQ-015 Vs edge vs. de edge in the same cycle: the vs clear wins, and row=0.
REQ-016 Line buffers LB1 and LB2 are each IMG_WIDTH x 1 bit, with combinational read at index col and synchronous write.
REQ-017 Each cycle with pre_de=1 and col<IMG_WIDTH: LB2[col] is written with LB1[col], and LB1[col] is written with pre_bit.
REQ-018 Cycles with col>=IMG_WIDTH perform no buffer write.
REQ-019 Stage 1: a 3x3 window register shifts by one column on each pre_de=1 cycle.
REQ-020 New window column: {pre_bit, LB1[col], LB2[col]}, covering rows r, r-1, r-2 at column c.
REQ-021 The window holds its value when pre_de=0.
REQ-022 Stage 1 also registers a valid flag, valid = (row>=2 && col>=2 && col<IMG_WIDTH), evaluated on the input pixel.
REQ-023 Stage 2 registers the result: pass gives centre W(r-1,c-1); erode gives the AND of all 9 bits; dilate gives the OR of all 9 bits; boundary gives centre AND NOT(erode).
REQ-024 Stage 2 result is forced to 0 when valid=0 or stage-1 de=0.
REQ-025 Latency is exactly 2 cycles: pre_vs and pre_de pass through two registers to give the EN=1 values of post_vs and post_de.
REQ-026 The post_bit result for input pixel (r,c) appears aligned with the delayed de of that pixel.
REQ-027 Mode is latched into mode_r on each pre_vs rising edge; mode changes mid-frame take effect from the next frame only.
REQ-028 Output mux is combinational: EN=1 gives the delayed vs, delayed de and stage-2 bit; EN=0 gives post_vs=pre_vs, post_de=pre_de, post_bit=0.
REQ-029 Internal counters, buffers and pipeline keep running regardless of EN.
REQ-030 Line buffers are not cleared between frames; the REQ-022 masking alone guarantees no stale data reaches the output.

Reset
REQ-031 With rst_n=0, the following are cleared asynchronously: col, row, window, valid, mode_r (00), the vs edge register, both delay stages and the result register.
REQ-032 Reset values with EN=1: post_vs=0, post_de=0, post_bit=0.
REQ-033 Line-buffer contents are undefined after reset and are not reset.
REQ-034 Reset asserted mid-frame: outputs go to 0 immediately; after release, output resumes correctly from the first pre_vs rising edge that follows.

Verification
REQ-035 Reset: assert rst_n=0 with EN=1 and random inputs -> post_vs, post_de and post_bit are 0 in the same cycle; after release, the first output de appears 2 cycles after the input de.
REQ-036 Erode: IMG_WIDTH=8, 8x6 frame, mode=01, all ones except pixel (3,3)=0 -> post_bit=0 for input positions r in 3..5 and c in 3..5; 1 for all other positions with r>=2, c>=2; 0 where r<2 or c<2.
REQ-037 Dilate: mode=10, all zeros except (2,2)=1 -> post_bit=1 only at input positions r in 2..4, c in 2..4; everything else 0.
REQ-038 Bypass: EN=0 with pre_de toggling -> post_vs=pre_vs and post_de=pre_de combinationally, post_bit=0; switching EN to 1 gives 2-cycle-delayed timing.
REQ-039 Frame-aligned mode: switch mode 01->10 mid-frame -> the remainder of the frame is still eroded; the next frame is dilated.
REQ-040 Overlong line: IMG_WIDTH=8, 10-pixel lines of all ones, mode=01 -> columns 8 and 9 output 0; the next row's columns 2..7 output 1, unaffected by the extra pixels.
